// File: rtl/mc_core_seq_pkg.sv
// mc_core_seq_pkg: shared definitions for the multi-cycle core sequencer.
//   - state_e  : sequencer state encoding (3 bits)
//   - CAUSE_*  : mcause codes raised by the sequencer
//   - XLEN_DEF : default datapath / PC width, INST_W: instruction width
//   - mem_cause: picks the load or store access-fault code
package mc_core_seq_pkg;

  localparam int XLEN_DEF = 32;
  localparam int INST_W   = 32;

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_IF_WAIT  = 3'd1,
    S_EXEC     = 3'd2,
    S_MEM      = 3'd3,
    S_MEM_WAIT = 3'd4,
    S_WB       = 3'd5,
    S_TRAP     = 3'd6,
    S_HALT     = 3'd7
  } state_e;

  localparam logic [3:0] CAUSE_IF_FAULT = 4'd1;
  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_LD_FAULT = 4'd5;
  localparam logic [3:0] CAUSE_ST_FAULT = 4'd7;

  function automatic logic [3:0] mem_cause(input logic is_store);
    return is_store ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
  endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// seq_timeout_cnt: response-wait watchdog.
//   clk, rst_n : clock, async active-low reset
//   clr        : restart the count (request accepted this cycle)
//   en         : a wait cycle is in progress
//   expire     : this is the TIMEOUT-th wait cycle; TIMEOUT=0 never expires
module seq_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // Value held during the last allowed wait cycle.
  localparam logic [W-1:0] LAST = (TIMEOUT == 0) ? '0 : W'(TIMEOUT - 1);

  logic [W-1:0] cnt;

  // Saturates at LAST so a stalled consumer never sees the count wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (en && cnt != LAST)  cnt <= cnt + 1'b1;
  end

  assign expire = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/mc_core_seq.sv
// mc_core_seq: multi-cycle core sequencer. Owns PC and instruction register,
// steps FETCH -> IF_WAIT -> EXEC -> [MEM -> MEM_WAIT] -> WB over valid/ready
// buses, raises traps on bus errors, illegal decode or wait timeouts, and
// counts retired instructions.
//   clk_i/rst_i        : clock, async active-low reset
//   ifu_*              : fetch request/response handshake, inst_i data
//   inst_o             : instruction register (drives idu)
//   dec_*              : idu class flags and write enables for inst_o
//   npc_i, mtvec_i     : next PC from exu, trap vector from csr
//   lsu_*              : memory request/response handshake
//   pc_o               : current PC / fetch address
//   reg_we_o, csr_we_o : one-cycle write strobes in WB
//   trap_*             : one-cycle trap strobe with cause and faulting PC
//   halt_o             : sticky ebreak halt
//   minstret_o         : retired instruction count
module mc_core_seq
  import mc_core_seq_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              TIMEOUT  = 255,
  parameter int              CNT_W    = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  output logic              ifu_req_valid_o,
  input  logic              ifu_req_ready_i,
  input  logic              ifu_resp_valid_i,
  input  logic              ifu_resp_err_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [INST_W-1:0] inst_o,
  input  logic              dec_is_load_i,
  input  logic              dec_is_store_i,
  input  logic              dec_is_ebreak_i,
  input  logic              dec_illegal_i,
  input  logic              dec_wenReg_i,
  input  logic              dec_wenCsr_i,
  input  logic [XLEN-1:0]   npc_i,
  input  logic [XLEN-1:0]   mtvec_i,
  output logic              lsu_req_valid_o,
  input  logic              lsu_req_ready_i,
  input  logic              lsu_resp_valid_i,
  input  logic              lsu_resp_err_i,
  output logic [XLEN-1:0]   pc_o,
  output logic              reg_we_o,
  output logic              csr_we_o,
  output logic              trap_o,
  output logic [3:0]        trap_cause_o,
  output logic [XLEN-1:0]   trap_epc_o,
  output logic              halt_o,
  output logic [CNT_W-1:0]  minstret_o
);

  state_e              state;
  logic [XLEN-1:0]     pc;
  logic [INST_W-1:0]   ir;
  logic                ifu_req, lsu_req;
  logic                reg_we, csr_we, trap, halt;
  logic [3:0]          cause;
  logic [XLEN-1:0]     epc;
  logic [CNT_W-1:0]    minstret;
  logic                is_store;
  logic                tmo_clr, tmo_en, tmo_expire;

  // Restart the watchdog on the accepting edge so the first wait cycle sees 0.
  assign tmo_clr = (ifu_req & ifu_req_ready_i) | (lsu_req & lsu_req_ready_i);
  assign tmo_en  = (state == S_IF_WAIT) || (state == S_MEM_WAIT);

  seq_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk    (clk_i),
    .rst_n  (rst_i),
    .clr    (tmo_clr),
    .en     (tmo_en),
    .expire (tmo_expire)
  );

  // Request valids are registers so reset drops them asynchronously. Coming
  // out of reset the first FETCH cycle launches the request, then it holds.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      ifu_req  <= 1'b0;
      lsu_req  <= 1'b0;
      reg_we   <= 1'b0;
      csr_we   <= 1'b0;
      trap     <= 1'b0;
      cause    <= '0;
      epc      <= '0;
      halt     <= 1'b0;
      minstret <= '0;
      is_store <= 1'b0;
    end else begin
      // strobes and trap info live for exactly one cycle
      reg_we <= 1'b0;
      csr_we <= 1'b0;
      trap   <= 1'b0;
      cause  <= '0;
      epc    <= '0;
      case (state)
        S_FETCH: begin
          if (!ifu_req) ifu_req <= 1'b1;
          else if (ifu_req_ready_i) begin
            ifu_req <= 1'b0;
            state   <= S_IF_WAIT;
          end
        end
        S_IF_WAIT: begin
          // a response in the expiring cycle still wins
          if (ifu_resp_valid_i) begin
            if (ifu_resp_err_i) begin
              trap  <= 1'b1;
              cause <= CAUSE_IF_FAULT;
              epc   <= pc;
              state <= S_TRAP;
            end else begin
              ir    <= inst_i;
              state <= S_EXEC;
            end
          end else if (tmo_expire) begin
            trap  <= 1'b1;
            cause <= CAUSE_IF_FAULT;
            epc   <= pc;
            state <= S_TRAP;
          end
        end
        S_EXEC: begin
          if (dec_illegal_i || (dec_is_load_i && dec_is_store_i)) begin
            trap  <= 1'b1;
            cause <= CAUSE_ILLEGAL;
            epc   <= pc;
            state <= S_TRAP;
          end else if (dec_is_ebreak_i) begin
            halt     <= 1'b1;
            minstret <= minstret + 1'b1;
            state    <= S_HALT;
          end else if (dec_is_load_i || dec_is_store_i) begin
            is_store <= dec_is_store_i;
            lsu_req  <= 1'b1;
            state    <= S_MEM;
          end else begin
            reg_we <= dec_wenReg_i;
            csr_we <= dec_wenCsr_i;
            state  <= S_WB;
          end
        end
        S_MEM: begin
          if (lsu_req_ready_i) begin
            lsu_req <= 1'b0;
            state   <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (lsu_resp_valid_i) begin
            if (lsu_resp_err_i) begin
              trap  <= 1'b1;
              cause <= mem_cause(is_store);
              epc   <= pc;
              state <= S_TRAP;
            end else begin
              reg_we <= dec_wenReg_i & ~is_store;
              csr_we <= dec_wenCsr_i;
              state  <= S_WB;
            end
          end else if (tmo_expire) begin
            trap  <= 1'b1;
            cause <= mem_cause(is_store);
            epc   <= pc;
            state <= S_TRAP;
          end
        end
        S_WB: begin
          pc       <= npc_i;
          minstret <= minstret + 1'b1;
          ifu_req  <= 1'b1;
          state    <= S_FETCH;
        end
        S_TRAP: begin
          pc      <= mtvec_i;
          ifu_req <= 1'b1;
          state   <= S_FETCH;
        end
        S_HALT: ;
        default: state <= S_FETCH;
      endcase
    end
  end

  assign ifu_req_valid_o = ifu_req;
  assign lsu_req_valid_o = lsu_req;
  assign inst_o          = ir;
  assign pc_o            = pc;
  assign reg_we_o        = reg_we;
  assign csr_we_o        = csr_we;
  assign trap_o          = trap;
  assign trap_cause_o    = cause;
  assign trap_epc_o      = epc;
  assign halt_o          = halt;
  assign minstret_o      = minstret;

endmodule

// File: tb/tb_mc_core_seq.sv
// tb_mc_core_seq: directed bench for mc_core_seq (TIMEOUT=8). A small bus
// responder plays ifu/lsu with knobs for hold, ready delay, response delay
// (-1 = never) and error; directed scenarios check strobes, traps and PC.
module tb_mc_core_seq;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] MTVEC  = 32'h8000_0100;

  logic        clk_i, rst_i;
  logic        ifu_req_valid_o, ifu_req_ready_i, ifu_resp_valid_i, ifu_resp_err_i;
  logic [31:0] inst_i, inst_o;
  logic        dec_is_load_i, dec_is_store_i, dec_is_ebreak_i, dec_illegal_i;
  logic        dec_wenReg_i, dec_wenCsr_i;
  logic [31:0] npc_i, mtvec_i;
  logic        lsu_req_valid_o, lsu_req_ready_i, lsu_resp_valid_i, lsu_resp_err_i;
  logic [31:0] pc_o, trap_epc_o;
  logic        reg_we_o, csr_we_o, trap_o, halt_o;
  logic [3:0]  trap_cause_o;
  logic [63:0] minstret_o;

  mc_core_seq #(.XLEN(32), .RESET_PC(RST_PC), .TIMEOUT(8), .CNT_W(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_req_valid_o(ifu_req_valid_o), .ifu_req_ready_i(ifu_req_ready_i),
    .ifu_resp_valid_i(ifu_resp_valid_i), .ifu_resp_err_i(ifu_resp_err_i),
    .inst_i(inst_i), .inst_o(inst_o),
    .dec_is_load_i(dec_is_load_i), .dec_is_store_i(dec_is_store_i),
    .dec_is_ebreak_i(dec_is_ebreak_i), .dec_illegal_i(dec_illegal_i),
    .dec_wenReg_i(dec_wenReg_i), .dec_wenCsr_i(dec_wenCsr_i),
    .npc_i(npc_i), .mtvec_i(mtvec_i),
    .lsu_req_valid_o(lsu_req_valid_o), .lsu_req_ready_i(lsu_req_ready_i),
    .lsu_resp_valid_i(lsu_resp_valid_i), .lsu_resp_err_i(lsu_resp_err_i),
    .pc_o(pc_o), .reg_we_o(reg_we_o), .csr_we_o(csr_we_o),
    .trap_o(trap_o), .trap_cause_o(trap_cause_o), .trap_epc_o(trap_epc_o),
    .halt_o(halt_o), .minstret_o(minstret_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  assign npc_i   = pc_o + 32'd4;  // exu: sequential flow
  assign mtvec_i = MTVEC;

  // responder knobs
  logic        ifu_hold, ifu_err, lsu_hold, lsu_err;
  int          ifu_rdy_wait, ifu_dly, lsu_dly;
  logic [31:0] ifu_inst;
  // responder state
  logic        if_pend, ls_pend;
  int          if_k, if_rc, ls_k;

  always @(negedge clk_i) begin
    ifu_req_ready_i  = 1'b0;
    ifu_resp_valid_i = 1'b0;
    ifu_resp_err_i   = 1'b0;
    lsu_req_ready_i  = 1'b0;
    lsu_resp_valid_i = 1'b0;
    lsu_resp_err_i   = 1'b0;
    if (!rst_i) begin
      if_pend = 1'b0; ls_pend = 1'b0; if_rc = 0; if_k = 0; ls_k = 0;
      inst_i  = '0;
    end else begin
      if (if_pend) begin
        if (if_k == ifu_dly) begin
          ifu_resp_valid_i = 1'b1;
          ifu_resp_err_i   = ifu_err;
          inst_i           = ifu_inst;
          if_pend          = 1'b0;
        end else if_k++;
      end else if (ifu_req_valid_o && !ifu_hold) begin
        if (if_rc < ifu_rdy_wait) if_rc++;
        else begin
          ifu_req_ready_i = 1'b1;
          if_rc = 0; if_k = 0;
          if_pend = (ifu_dly >= 0);
        end
      end
      if (ls_pend) begin
        if (ls_k == lsu_dly) begin
          lsu_resp_valid_i = 1'b1;
          lsu_resp_err_i   = lsu_err;
          ls_pend          = 1'b0;
        end else ls_k++;
      end else if (lsu_req_valid_o && !lsu_hold) begin
        lsu_req_ready_i = 1'b1;
        ls_k = 0;
        ls_pend = (lsu_dly >= 0);
      end
    end
  end

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // per-run statistics
  int          n_ifu_v, n_we, n_csr, n_trap, n_lsu_v, trap_at, pc_moves;
  logic [3:0]  cause_seen;
  logic [31:0] epc_seen, vpc;
  logic [31:0] fetch_q[$];

  task automatic tick();
    @(negedge clk_i); #1;
  endtask

  task automatic set_dec(input logic ld, st, eb, ill, wr, wc);
    dec_is_load_i = ld; dec_is_store_i = st; dec_is_ebreak_i = eb;
    dec_illegal_i = ill; dec_wenReg_i = wr; dec_wenCsr_i = wc;
  endtask

  // Release the parked fetch, observe n cycles, re-park at cycle n, then
  // advance one more cycle so the post-edge state is visible.
  task automatic run(input int n);
    n_ifu_v = 0; n_we = 0; n_csr = 0; n_trap = 0; n_lsu_v = 0;
    trap_at = -1; pc_moves = 0; cause_seen = '0; epc_seen = '0; vpc = '0;
    fetch_q.delete();
    ifu_hold = 1'b0;
    for (int t = 1; t <= n; t++) begin
      tick();
      if (ifu_req_valid_o) begin
        if (n_ifu_v > 0 && pc_o != vpc) pc_moves++;
        vpc = pc_o;
        n_ifu_v++;
        if (ifu_req_ready_i) fetch_q.push_back(pc_o);
      end
      if (lsu_req_valid_o) n_lsu_v++;
      if (reg_we_o) n_we++;
      if (csr_we_o) n_csr++;
      if (trap_o) begin
        n_trap++;
        if (trap_at < 0) trap_at = t;
        cause_seen = trap_cause_o;
        epc_seen   = trap_epc_o;
      end
      if (t == n) ifu_hold = 1'b1;
    end
    tick();
  endtask

  initial begin
    rst_i = 1'b0;
    ifu_hold = 1'b1; ifu_err = 1'b0; ifu_rdy_wait = 0; ifu_dly = 0;
    ifu_inst = 32'h0010_0093;
    lsu_hold = 1'b0; lsu_err = 1'b0; lsu_dly = 0;
    set_dec(0, 0, 0, 0, 1, 0);
    tick(); tick();
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_inst", inst_o, 0);
    chk("rst_minstret", minstret_o, 0);
    chk("rst_ifu_valid", ifu_req_valid_o, 0);
    chk("rst_lsu_valid", lsu_req_valid_o, 0);
    chk("rst_trap_halt", {trap_o, halt_o, reg_we_o, csr_we_o}, 0);
    rst_i = 1'b1;
    tick();
    chk("park_valid", ifu_req_valid_o, 1);

    // zero-wait ALU stream: 10 instructions in 40 cycles
    run(40);
    chk("alu_fetches", fetch_q.size(), 10);
    for (int i = 0; i < 10 && i < fetch_q.size(); i++)
      chk($sformatf("alu_fetch_pc%0d", i), fetch_q[i], RST_PC + 32'(4 * i));
    chk("alu_reg_we", n_we, 10);
    chk("alu_no_trap", n_trap, 0);
    chk("alu_minstret", minstret_o, 10);
    chk("alu_pc", pc_o, RST_PC + 32'd40);
    chk("alu_inst", inst_o, 32'h0010_0093);

    // slow fetch: ready after 3 low cycles, response delay 2
    ifu_rdy_wait = 3; ifu_dly = 2; ifu_inst = 32'hDEAD_0013;
    run(9);
    chk("slow_valid_cycles", n_ifu_v, 4);
    chk("slow_pc_stable", pc_moves, 0);
    chk("slow_fetch_pc", (fetch_q.size() > 0) ? fetch_q[0] : 32'h0, RST_PC + 32'd40);
    chk("slow_inst", inst_o, 32'hDEAD_0013);
    chk("slow_no_trap", n_trap, 0);
    chk("slow_minstret", minstret_o, 11);
    ifu_rdy_wait = 0; ifu_dly = 0;

    // load with bus error -> cause 5, vector to mtvec
    set_dec(1, 0, 0, 0, 1, 0); lsu_err = 1'b1;
    run(6);
    chk("ld_err_trap_n", n_trap, 1);
    chk("ld_err_trap_at", trap_at, 6);
    chk("ld_err_cause", cause_seen, 5);
    chk("ld_err_epc", epc_seen, RST_PC + 32'd44);
    chk("ld_err_no_we", n_we, 0);
    chk("ld_err_lsu_valid", n_lsu_v, 1);
    chk("ld_err_next_pc", pc_o, MTVEC);
    chk("ld_err_minstret", minstret_o, 11);
    chk("post_trap_clear", {trap_o, trap_cause_o, trap_epc_o}, 0);

    // zero-wait store: 6 cycles, no reg write even with wenReg
    set_dec(0, 1, 0, 0, 1, 0); lsu_err = 1'b0;
    run(6);
    chk("st_no_we", n_we, 0);
    chk("st_no_trap", n_trap, 0);
    chk("st_minstret", minstret_o, 12);
    chk("st_pc", pc_o, MTVEC + 32'd4);

    // fetch bus error -> cause 1
    set_dec(0, 0, 0, 0, 1, 0); ifu_err = 1'b1;
    run(3);
    chk("if_err_trap_at", trap_at, 3);
    chk("if_err_cause", cause_seen, 1);
    chk("if_err_epc", epc_seen, MTVEC + 32'd4);
    chk("if_err_pc", pc_o, MTVEC);
    ifu_err = 1'b0;

    // fetch never answers -> timeout trap 8 cycles after acceptance
    ifu_dly = -1;
    run(10);
    chk("tmo_trap_n", n_trap, 1);
    chk("tmo_trap_at", trap_at, 10);
    chk("tmo_cause", cause_seen, 1);
    chk("tmo_epc", epc_seen, MTVEC);
    chk("tmo_minstret", minstret_o, 12);

    // response in the expiring cycle wins
    ifu_dly = 7; ifu_inst = 32'h0020_0113;
    run(11);
    chk("tmo_edge_no_trap", n_trap, 0);
    chk("tmo_edge_we", n_we, 1);
    chk("tmo_edge_minstret", minstret_o, 13);
    chk("tmo_edge_pc", pc_o, MTVEC + 32'd4);
    ifu_dly = 0;

    // illegal instruction, then load+store both set
    set_dec(0, 0, 0, 1, 1, 1);
    run(4);
    chk("ill_trap_at", trap_at, 4);
    chk("ill_cause", cause_seen, 2);
    chk("ill_epc", epc_seen, MTVEC + 32'd4);
    chk("ill_no_we", n_we + n_csr, 0);
    set_dec(1, 1, 0, 0, 1, 0);
    run(4);
    chk("ldst_cause", cause_seen, 2);
    chk("ldst_no_lsu", n_lsu_v, 0);
    chk("ldst_minstret", minstret_o, 13);

    // csr write strobe
    set_dec(0, 0, 0, 0, 0, 1);
    run(4);
    chk("csr_we", n_csr, 1);
    chk("csr_no_reg_we", n_we, 0);

    // ebreak: sticky halt, no further fetches, counted
    set_dec(0, 0, 1, 0, 0, 0);
    run(4);
    chk("halt", halt_o, 1);
    chk("halt_minstret", minstret_o, 15);
    run(6);
    chk("halt_no_fetch", n_ifu_v, 0);
    chk("halt_sticky", halt_o, 1);

    // reset while a memory request is stalled: valid drops without a clock
    rst_i = 1'b0; tick(); rst_i = 1'b1; tick();
    chk("rst_clears_halt", halt_o, 0);
    set_dec(1, 0, 0, 0, 1, 0); lsu_hold = 1'b1;
    run(4);
    chk("mem_stall_valid", lsu_req_valid_o, 1);
    #2 rst_i = 1'b0; #1;
    chk("async_lsu_valid", lsu_req_valid_o, 0);
    chk("async_pc", pc_o, RST_PC);
    tick(); rst_i = 1'b1; tick();
    lsu_hold = 1'b0;

    // reset in MEM_WAIT with no response coming
    lsu_dly = -1;
    run(5);
    chk("memwait_no_valid", {lsu_req_valid_o, ifu_req_valid_o}, 0);
    #2 rst_i = 1'b0; #1;
    chk("memwait_rst_valids", {lsu_req_valid_o, ifu_req_valid_o}, 0);
    chk("memwait_rst_minstret", minstret_o, 0);
    tick(); rst_i = 1'b1; tick();
    chk("memwait_rel_pc", pc_o, RST_PC);
    chk("memwait_rel_minstret", minstret_o, 0);
    chk("memwait_rel_fetch", ifu_req_valid_o, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
